// File: rtl/hzu_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hzu_scoreboard_pkg
// Shared types for the fetch/decode hazard unit: thread id, instruction
// format, history entry layout and small opcode-classification helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package hzu_scoreboard_pkg;

    localparam int HZU_NTHREADS = 4;
    localparam int HZU_TID_W    = (HZU_NTHREADS > 1) ? $clog2(HZU_NTHREADS) : 1;
    localparam int REG_W        = 5;

    typedef logic [HZU_TID_W-1:0] threadid_t;
    typedef logic [REG_W-1:0]     regidx_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LDB  = 4'd6,
        OP_LDW  = 4'd7,
        OP_STB  = 4'd8,
        OP_STW  = 4'd9,
        OP_BEQ  = 4'd10,
        OP_JMP  = 4'd11
    } op_t;

    typedef struct packed {
        op_t     op;
        regidx_t dst;
        regidx_t src1;
        regidx_t src2;
    } instr_t;

    typedef struct packed {
        logic      valid;
        threadid_t thread;
        regidx_t   dst;
        logic      wr;
        logic      st;
    } history_entry_t;

    // True for opcodes that produce a register result in dst.
    function automatic logic writes_dst(instr_t i);
        case (i.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDB, OP_LDW: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

    // True for opcodes whose src2 field names a register that is read
    // (stores read it as the data operand, branches as the comparand).
    function automatic logic reads_src2(instr_t i);
        case (i.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STB, OP_STW, OP_BEQ: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(instr_t i);
        case (i.op)
            OP_LDB, OP_LDW, OP_STB, OP_STW: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(instr_t i);
        return (i.op == OP_STB) || (i.op == OP_STW);
    endfunction

endpackage

// File: rtl/hzu_stall_counter.sv
// ---------------------------------------------------------------------------
// hzu_stall_counter
// One saturating event counter; holds at all-ones instead of wrapping.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset, clears the count
//   i_inc    count one event this cycle
//   o_count  current count (CNT_W bits)
// ---------------------------------------------------------------------------
module hzu_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Increment on request, but freeze once every bit is set so a long
    // stall never makes the counter look small again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hzu_scoreboard.sv
// ---------------------------------------------------------------------------
// hzu_scoreboard
// Same-cycle issue/stall decision for the fetch/decode boundary. Keeps a
// DEPTH-deep shift register of issued instructions (thread, dst, writes,
// store) and blocks same-thread RAW readers, loads/stores right behind a
// store (optional, all threads), and candidates that missed or are flushed.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid              candidate instruction present
//   in_thread, in_instr   candidate thread and instruction
//   itlb_miss/icache_miss fetch misses for the candidate
//   flush, flush_thread   squash history of one thread at the next edge
//   issue                 candidate accepted this cycle
//   stall                 candidate blocked by RAW/MEM hazard, hold it
//   cause                 {miss/flush, MEM, RAW}, zero while in_valid=0
//   stall_cnt             per-thread saturating stall counters
// ---------------------------------------------------------------------------
module hzu_scoreboard
    import hzu_scoreboard_pkg::*;
#(
    parameter int NTHREADS      = HZU_NTHREADS,
    parameter int DEPTH         = 8,
    parameter int MEM_SERIALIZE = 1,
    parameter int CNT_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  threadid_t                 in_thread,
    input  instr_t                    in_instr,
    input  logic                      itlb_miss,
    input  logic                      icache_miss,
    input  logic                      flush,
    input  threadid_t                 flush_thread,
    output logic                      issue,
    output logic                      stall,
    output logic [2:0]                cause,
    output logic [NTHREADS*CNT_W-1:0] stall_cnt
);

    history_entry_t r_hist     [DEPTH];
    history_entry_t w_histNext [DEPTH];
    logic           w_raw;
    logic           w_mem;
    logic           w_miss;
    logic           w_incVec   [NTHREADS];

    // RAW search over the whole history. Several matching writers simply
    // OR together into one raw flag; other threads' writers are ignored.
    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_hist[i].valid && r_hist[i].wr && (r_hist[i].thread == in_thread) &&
                ((r_hist[i].dst == in_instr.src1) ||
                 (reads_src2(in_instr) && (r_hist[i].dst == in_instr.src2)))) begin
                w_raw = 1'b1;
            end
        end
        w_raw = w_raw & in_valid;
    end

    // Memory serialisation looks only at the youngest entry and deliberately
    // ignores thread: the memory port is shared by all threads. A miss or a
    // flush of the candidate's own thread means fetch will refetch, so it
    // kills issue without counting as a stall.
    always_comb begin
        w_mem  = (MEM_SERIALIZE != 0) && in_valid && r_hist[0].valid &&
                 r_hist[0].st && is_mem(in_instr);
        w_miss = itlb_miss || icache_miss || (flush && (flush_thread == in_thread));
        issue  = in_valid && !w_raw && !w_mem && !w_miss;
        stall  = in_valid && (w_raw || w_mem) && !w_miss;
        cause  = {in_valid && w_miss, w_mem, w_raw};
    end

    // Next history: the accepted candidate (or a bubble) enters at slot 0,
    // everything else moves one slot older, then the flushed thread's
    // entries are invalidated. An issued candidate can never belong to the
    // flushed thread, so clearing slot 0 too is harmless.
    always_comb begin
        w_histNext[0] = '0;
        if (issue) begin
            w_histNext[0].valid  = 1'b1;
            w_histNext[0].thread = in_thread;
            w_histNext[0].dst    = in_instr.dst;
            w_histNext[0].wr     = writes_dst(in_instr);
            w_histNext[0].st     = is_store(in_instr);
        end
        for (int i = 1; i < DEPTH; i++) begin
            w_histNext[i] = r_hist[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && (w_histNext[i].thread == flush_thread)) begin
                w_histNext[i].valid = 1'b0;
            end
        end
    end

    // History register; reset empties it immediately so no stale writer
    // survives into the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= w_histNext[i];
            end
        end
    end

    // One saturating stall counter per thread, bumped when that thread's
    // candidate is stalled.
    for (genvar t = 0; t < NTHREADS; t++) begin : g_cnt
        assign w_incVec[t] = stall && (in_thread == threadid_t'(t));

        hzu_stall_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .i_inc   (w_incVec[t]),
            .o_count (stall_cnt[t*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/hzu_scoreboard.md
Name: hzu_scoreboard

Overview:
- Parametrised hazard unit at the fetch/decode boundary. Makes a same-cycle issue/stall decision for each candidate instruction.
- Tracks a DEPTH-deep history of issued instructions, tagged by hardware thread. Detects RAW hazards on both sources, restricted to the same thread.
- Enforces the memory-serialisation rule (no load/store directly after a store) behind a parameter.
- Supports per-thread flush and keeps per-thread stall counters.

Parameters:
- NTHREADS, 4, number of hardware threads; threadid_t is $clog2(NTHREADS) bits.
- DEPTH, 8, history entries; a writer blocks readers for DEPTH cycles after issue (DEPTH >= 1).
- MEM_SERIALIZE, 1, 1 = stall a load/store issued the cycle after any store (all threads); 0 = off.
- CNT_W, 16, width of each per-thread saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  candidate instruction present
- in_thread  in  threadid_t  thread of candidate
- in_instr  in  instr_t  candidate instruction
- itlb_miss  in  1  I-TLB miss for candidate
- icache_miss  in  1  I-cache miss for candidate
- flush  in  1  squash in-flight history of flush_thread
- flush_thread  in  threadid_t  thread being flushed
- issue  out  1  candidate accepted this cycle
- stall  out  1  candidate valid but blocked by a hazard; fetch must hold it
- cause  out  3  [0] RAW, [1] MEM, [2] miss/flush; valid only while in_valid
- stall_cnt  out  NTHREADS*CNT_W  per-thread stall counters, thread t at [t*CNT_W +: CNT_W]

Behaviour:
- History is a shift register hist[0..DEPTH-1]. Each entry holds: valid, thread, dst, wr (writes dst), st (is store).
- On every clk edge: hist[i+1] <= hist[i], and hist[DEPTH-1] is dropped.
  - hist[0] <= candidate if issue, else a bubble (valid=0).
- raw = in_valid AND some hist[i] meets all of: valid, wr, same thread as in_thread, and dst equal to src1, or to src2 when reads_src2(in_instr).
- mem = MEM_SERIALIZE AND in_valid AND hist[0].valid AND hist[0].st AND in_instr.op in {ldb, ldw, stb, stw}. This check ignores thread.
- miss = itlb_miss OR icache_miss OR (flush AND flush_thread == in_thread).
- issue = in_valid AND NOT raw AND NOT mem AND NOT miss. This is combinational: zero-latency decision, state updated at the next edge.
- stall = in_valid AND (raw OR mem) AND NOT miss. A miss is not a stall: the fetch unit refetches.
- Flush: at the edge, every entry with thread == flush_thread gets valid <= 0, applied after the shift. A candidate issued in the same cycle for a different thread is inserted normally.
- Counters: stall_cnt[in_thread] increments when stall=1 and saturates at 2^CNT_W-1. No wrap.
- Reset: all hist valid=0 and all counters 0, effective immediately (async).
  - With in_valid=0, issue=0, stall=0, cause=0.
  - Reset asserted mid-stall discards the whole history. After release the first candidate issues with no hazard.
- Boundaries:
  - A writer issued at cycle n blocks same-thread readers through cycle n+DEPTH. A reader at n+DEPTH+1 issues.
  - Multiple matching entries give a single raw.
  - raw and mem together set both cause bits.
  - A dst match from another thread never stalls.
- Candidate held by fetch across a stall: the history keeps shifting bubbles, so the stall ends by itself.

Decomposition:
- The common package gets:
  - history_entry_t extended with wr and st fields.
  - Functions writes_dst(instr_t), reads_src2(instr_t) and is_mem(instr_t), using existing opcode values.
  - A threadid_t definition sized from NTHREADS.
- One sub-module, hzu_stall_counter: a single saturating CNT_W counter with inc. It is instantiated NTHREADS times via generate.

Test Plan:
- Thread 0: add r3 issues at cycle 0, then thread 0 reads r3 as src2 at cycle 1 → issue=0, stall=1, cause=3'b001. Holding the reader, DEPTH=8: issue=1 at cycle 9.
- Thread 0 writes r3, then thread 1 reads r3 next cycle → issue=1, stall=0.
- stw issues, next cycle ldw from another thread → stall=1, cause=3'b010. With MEM_SERIALIZE=0 → issue=1.
- Thread 2 writes r5, flush with flush_thread=2 next cycle, then thread 2 reads r5 → issue=1. A thread-2 candidate during the flush cycle → issue=0, cause=3'b100, stall=0.
- CNT_W=4: hold thread 1 stalled for 20 cycles → stall_cnt[1]=15 (saturated), other counters 0.
- Assert rst asynchronously between edges while hist is full of writers → counters 0 immediately. After release, a dependent reader issues on its first cycle.
